baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
- Parametrised baud/oversample tick generator for the UART TX/RX path.
- Produces single-cycle enable pulses, not a derived clock:
  - `os_tick`: oversample rate.
  - `mid_tick`: mid-bit sample point.
  - `bit_tick`: bit boundary.
- Also produces `os_clk`, a 50 % square wave at half the `os_tick` rate, for legacy consumers.
- The divisor is runtime-reloadable. `sync` re-phases the generator, so RX can align to a start-bit edge.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, default baud rate after reset.
- OVERSAMPLE, 16, oversample ticks per bit. Must be even and ≥ 2.
- DIV_WIDTH, 16, width of the divisor and clock counter.
- DEF_DIV, (CLK_FREQ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE), reset divisor. Rounded; 651 at the defaults. Must be ≥ 1 and < 2^DIV_WIDTH.

Ports:
- clk, in, 1, system clock. All logic is on the rising edge.
- reset, in, 1, synchronous, active-high reset.
- en, in, 1, count enable. When low, all state holds.
- sync, in, 1, phase restart pulse.
- div_load, in, 1, load request for div_in.
- div_in, in, DIV_WIDTH, new divisor in clk cycles per os_tick.
- os_tick, out, 1, 1-cycle pulse every D enabled cycles.
- mid_tick, out, 1, 1-cycle pulse at oversample index OVERSAMPLE/2-1.
- bit_tick, out, 1, 1-cycle pulse at oversample index OVERSAMPLE-1.
- os_clk, out, 1, toggles on every os_tick.
- div_cur, out, DIV_WIDTH, divisor currently in use (D).
- div_err, out, 1, 1-cycle pulse when a load of 0 is rejected.

Behaviour:
- Clock and reset:
  - One clock, `clk`. Reset is synchronous and active-high; `reset` has top priority.
  - Reset values:
    - `cnt` = 0, `os_cnt` = 0, `D` = DEF_DIV, pending-valid = 0.
    - `os_tick`, `mid_tick`, `bit_tick`, `os_clk`, `div_err` = 0.
    - `div_cur` = DEF_DIV.
- Registered outputs:
  - All outputs are registered. Each tick output is high for exactly one cycle.
  - Outside a pulse cycle, tick outputs are 0.
- Clock counter `cnt` (DIV_WIDTH bits, range 0..D-1):
  - On each edge with en=1 and sync=0:
    - If cnt == D-1: cnt <= 0 and os_tick <= 1 (a "wrap").
    - Otherwise: cnt <= cnt+1.
  - Resulting timing: the first os_tick is visible D edges after the first enabled edge, then one every D cycles.
  - D = 1 gives os_tick high continuously while en=1.
- Oversample counter `os_cnt` (range 0..OVERSAMPLE-1):
  - Advances on each wrap and wraps to 0 after OVERSAMPLE-1.
  - On a wrap with os_cnt == OVERSAMPLE/2-1: mid_tick <= 1.
  - On a wrap with os_cnt == OVERSAMPLE-1: bit_tick <= 1.
  - Ticks that coincide are asserted in the same cycle (os_tick together with mid_tick or bit_tick).
- os_clk:
  - Toggles on every wrap, giving period 2·D cycles.
- en = 0:
  - cnt, os_cnt and os_clk hold.
  - No tick is emitted. Any tick already registered is cleared on the next edge.
- sync = 1 (priority over en; ignored during reset):
  - cnt <= 0, os_cnt <= 0, all ticks <= 0, os_clk <= 0.
  - A pending divisor is applied immediately.
  - After sync, the first mid_tick occurs (OVERSAMPLE/2)·D enabled cycles later.
- Divisor load:
  - When div_load = 1 and div_in ≠ 0, div_in is latched as pending and pending-valid is set. A later load overwrites the pending value.
  - A pending divisor is applied at the next wrap edge. It is applied immediately when en = 0, or on sync.
  - cnt restarts from 0 under the new D.
  - A running period is never truncated or stretched mid-count.
  - div_cur updates on the same edge that D changes.
  - When div_load = 1 and div_in = 0: no change to D or pending, and div_err <= 1 for one cycle.
  - Load and wrap in the same cycle: the new value becomes pending and applies at the following wrap. The old pending value is applied now.
- Reset mid-operation:
  - Reset discards the pending divisor and restores DEF_DIV.
  - The first os_tick is D edges after reset deasserts (with en=1).

Test Plan:
- Reset defaults:
  - Assert reset 3 cycles, then release with en=1. Require div_cur=651 and all ticks 0.
  - Require the first os_tick on edge 651 and bit_tick on edge 651·16 = 10416.
- Small divisor:
  - Load div_in=4 with en=0, then enable.
  - Require os_tick every 4 cycles, os_clk period 8.
  - Require mid_tick coincident with the 8th os_tick and bit_tick with the 16th, repeating every 64 cycles.
- Live reload:
  - With D=4 running, load div_in=6 at cnt=1.
  - Require the current period to finish at 4 cycles, subsequent periods of 6, and div_cur=6 from the wrap edge.
- Zero load:
  - With D=4, pulse div_load with div_in=0.
  - Require one div_err pulse and div_cur stays 4, with no change in tick timing.
- sync:
  - With D=4, pulse sync mid-bit (os_cnt=11).
  - Require ticks low and os_clk=0 the next cycle, the next os_tick 4 cycles later, and mid_tick 32 cycles after the sync edge.
- en gating and reset mid-run:
  - Drop en for 10 cycles at cnt=2. Require no ticks, and an os_tick 2 cycles after re-enable.
  - Assert reset while a pending load of 9 exists. Require div_cur=651 after reset and the load lost.

Source files
------------

// File: rtl/baud_tick_gen.sv
// UART baud/oversample tick generator: single-cycle enable pulses at the
// oversample rate, mid-bit and bit boundary, with a reloadable divisor.
module baud_tick_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int DEF_DIV    = (CLK_FREQ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 os_tick,
  output logic                 mid_tick,
  output logic                 bit_tick,
  output logic                 os_clk,
  output logic [DIV_WIDTH-1:0] div_cur,
  output logic                 div_err
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_WIDTH-1:0] DEF_D    = DIV_WIDTH'(DEF_DIV);
  localparam logic [OS_W-1:0]      MID_IDX  = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0]      LAST_IDX = OS_W'(OVERSAMPLE - 1);

  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] d, d_n;
  logic [DIV_WIDTH-1:0] pend, pend_n;
  logic                 pend_v, pend_v_n;
  logic [OS_W-1:0]      os_cnt, os_cnt_n;
  logic                 os_tick_n, mid_tick_n, bit_tick_n, os_clk_n, div_err_n;
  logic                 wrap, load_ok, load_zero;

  assign wrap      = (cnt == d - DIV_WIDTH'(1));
  assign load_ok   = div_load && (div_in != '0);
  assign load_zero = div_load && (div_in == '0);
  assign div_cur   = d;

  always_comb begin
    cnt_n      = cnt;
    os_cnt_n   = os_cnt;
    d_n        = d;
    pend_n     = pend;
    pend_v_n   = pend_v;
    os_tick_n  = 1'b0;
    mid_tick_n = 1'b0;
    bit_tick_n = 1'b0;
    os_clk_n   = os_clk;
    div_err_n  = load_zero;

    if (sync) begin
      cnt_n    = '0;
      os_cnt_n = '0;
      os_clk_n = 1'b0;
      if (pend_v) begin
        d_n      = pend;
        pend_v_n = 1'b0;
      end
    end else if (en) begin
      if (wrap) begin
        cnt_n     = '0;
        os_tick_n = 1'b1;
        os_clk_n  = ~os_clk;
        mid_tick_n = (os_cnt == MID_IDX);
        if (os_cnt == LAST_IDX) begin
          os_cnt_n   = '0;
          bit_tick_n = 1'b1;
        end else begin
          os_cnt_n = os_cnt + OS_W'(1);
        end
        // A new divisor only takes effect on a period boundary.
        if (pend_v) begin
          d_n      = pend;
          pend_v_n = 1'b0;
        end
      end else begin
        cnt_n = cnt + DIV_WIDTH'(1);
      end
    end else if (pend_v) begin
      d_n      = pend;
      pend_v_n = 1'b0;
      cnt_n    = '0;
    end

    // Placed last so a load coinciding with an apply becomes the next pending value.
    if (load_ok) begin
      pend_n   = div_in;
      pend_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      os_cnt   <= '0;
      d        <= DEF_D;
      pend     <= '0;
      pend_v   <= 1'b0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      os_clk   <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      os_cnt   <= os_cnt_n;
      d        <= d_n;
      pend     <= pend_n;
      pend_v   <= pend_v_n;
      os_tick  <= os_tick_n;
      mid_tick <= mid_tick_n;
      bit_tick <= bit_tick_n;
      os_clk   <= os_clk_n;
      div_err  <= div_err_n;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios plus randomized
// enable/divisor runs against an arithmetic model of tick timing.
module tb_baud_tick_gen;

  localparam int OS  = 16;
  localparam int DW  = 16;
  localparam int DEF = 651;

  logic          clk = 1'b0;
  logic          reset, en, sync, div_load;
  logic [DW-1:0] div_in;
  logic          os_tick, mid_tick, bit_tick, os_clk, div_err;
  logic [DW-1:0] div_cur;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: m_n counts enabled edges since the last phase restart.
  int m_n, m_d;
  bit e_os, e_mid, e_bit, e_clk;

  baud_tick_gen dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync),
    .div_load(div_load), .div_in(div_in),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
    .os_clk(os_clk), .div_cur(div_cur), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_restart(input int d);
    m_n = 0;
    m_d = d;
  endtask

  task automatic model_edge(input bit en_v);
    int k;
    if (en_v) m_n++;
    k     = m_n / m_d;
    e_os  = en_v && (m_n % m_d == 0);
    e_mid = e_os && (k % OS == OS/2);
    e_bit = e_os && (k % OS == 0);
    e_clk = (k % 2) == 1;
  endtask

  task automatic test_reset();
    int first_os, first_mid, first_bit, bad, first_bad;
    reset = 1; en = 1; sync = 0; div_load = 0; div_in = '0;
    repeat (3) cycle();
    tests_run++;
    if ({os_tick, mid_tick, bit_tick, os_clk, div_err} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b, expected 00000",
               {os_tick, mid_tick, bit_tick, os_clk, div_err});
    end
    tests_run++;
    if (div_cur !== DW'(DEF)) begin
      tests_failed++;
      $display("[TB] FAIL reset_div_cur: got %0d, expected %0d", div_cur, DEF);
    end
    reset = 0;
    model_restart(DEF);
    first_os = -1; first_mid = -1; first_bit = -1; bad = 0; first_bad = -1;
    for (int k = 1; k <= 10420; k++) begin
      cycle();
      model_edge(1'b1);
      if (os_tick === 1'b1 && first_os < 0) first_os = k;
      if (mid_tick === 1'b1 && first_mid < 0) first_mid = k;
      if (bit_tick === 1'b1 && first_bit < 0) first_bit = k;
      if (os_tick !== e_os || mid_tick !== e_mid || bit_tick !== e_bit || os_clk !== e_clk) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    tests_run++;
    if (first_os !== 651) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_os: edge %0d, expected 651", first_os);
    end
    tests_run++;
    if (first_mid !== 5208) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_mid: edge %0d, expected 5208", first_mid);
    end
    tests_run++;
    if (first_bit !== 10416) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_bit: edge %0d, expected 10416", first_bit);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_run_model: %0d bad cycles (first edge %0d), expected 0", bad, first_bad);
    end
  endtask

  task automatic test_small_div();
    int bad, n_os, n_mid, n_bit;
    reset = 1; en = 0; cycle(); reset = 0;
    div_load = 1; div_in = DW'(4); cycle();
    div_load = 0; cycle();
    tests_run++;
    if (div_cur !== DW'(4)) begin
      tests_failed++;
      $display("[TB] FAIL small_div_cur: got %0d, expected 4", div_cur);
    end
    en = 1;
    model_restart(4);
    bad = 0; n_os = 0; n_mid = 0; n_bit = 0;
    for (int k = 1; k <= 192; k++) begin
      cycle();
      model_edge(1'b1);
      n_os  += int'(os_tick === 1'b1);
      n_mid += int'(mid_tick === 1'b1);
      n_bit += int'(bit_tick === 1'b1);
      if (os_tick !== e_os || mid_tick !== e_mid || bit_tick !== e_bit ||
          os_clk !== e_clk || div_cur !== DW'(4)) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL small_div_model: %0d bad cycles, expected 0", bad);
    end
    tests_run++;
    if (n_os !== 48 || n_mid !== 3 || n_bit !== 3) begin
      tests_failed++;
      $display("[TB] FAIL small_div_counts: os/mid/bit %0d/%0d/%0d, expected 48/3/3", n_os, n_mid, n_bit);
    end
  endtask

  task automatic test_live_reload();
    int bad, first_os;
    bit exp_os;
    int exp_div;
    cycle();
    model_edge(1'b1);
    div_load = 1; div_in = DW'(6);
    bad = 0; first_os = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      div_load = 0;
      exp_os  = (k >= 3) && ((k - 3) % 6 == 0);
      exp_div = (k >= 3) ? 6 : 4;
      if (os_tick === 1'b1 && first_os < 0) first_os = k;
      if (os_tick !== exp_os || div_cur !== DW'(exp_div)) bad++;
    end
    tests_run++;
    if (first_os !== 3) begin
      tests_failed++;
      $display("[TB] FAIL reload_first_os: edge %0d, expected 3", first_os);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reload_periods: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_zero_load();
    int bad, n_err;
    bit e_err;
    en = 0; div_load = 1; div_in = DW'(4); cycle();
    div_load = 0; cycle();
    en = 1; sync = 1; cycle(); sync = 0;
    model_restart(4);
    bad = 0; n_err = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 10) begin div_load = 1; div_in = '0; end
      cycle();
      div_load = 0;
      model_edge(1'b1);
      e_err = (k == 10);
      n_err += int'(div_err === 1'b1);
      if (os_tick !== e_os || mid_tick !== e_mid || bit_tick !== e_bit ||
          os_clk !== e_clk || div_err !== e_err || div_cur !== DW'(4)) bad++;
    end
    tests_run++;
    if (n_err !== 1) begin
      tests_failed++;
      $display("[TB] FAIL zero_load_err_pulses: %0d, expected 1", n_err);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL zero_load_model: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_sync();
    int guard, bad, first_os, first_mid;
    guard = 0;
    while (!(((m_n / m_d) % OS == 11) && (m_n % m_d == 2)) && guard < 200) begin
      cycle();
      model_edge(1'b1);
      guard++;
    end
    tests_run++;
    if (guard >= 200) begin
      tests_failed++;
      $display("[TB] FAIL sync_setup: phase not reached, got %0d edges, expected < 200", guard);
    end
    sync = 1; cycle(); sync = 0;
    tests_run++;
    if ({os_tick, mid_tick, bit_tick, os_clk} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL sync_clear: got %b, expected 0000", {os_tick, mid_tick, bit_tick, os_clk});
    end
    model_restart(4);
    bad = 0; first_os = -1; first_mid = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      model_edge(1'b1);
      if (os_tick === 1'b1 && first_os < 0) first_os = k;
      if (mid_tick === 1'b1 && first_mid < 0) first_mid = k;
      if (os_tick !== e_os || mid_tick !== e_mid || bit_tick !== e_bit || os_clk !== e_clk) bad++;
    end
    tests_run++;
    if (first_os !== 4 || first_mid !== 32) begin
      tests_failed++;
      $display("[TB] FAIL sync_rephase: first os/mid %0d/%0d, expected 4/32", first_os, first_mid);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL sync_model: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_en_gating();
    int guard, bad, first_os;
    guard = 0;
    while (m_n % m_d != 2 && guard < 10) begin
      cycle();
      model_edge(1'b1);
      guard++;
    end
    en = 0;
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      model_edge(1'b0);
      if ({os_tick, mid_tick, bit_tick} !== 3'b0 || os_clk !== e_clk) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL en_hold: %0d bad cycles, expected 0", bad);
    end
    en = 1;
    bad = 0; first_os = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      model_edge(1'b1);
      if (os_tick === 1'b1 && first_os < 0) first_os = k;
      if (os_tick !== e_os || mid_tick !== e_mid || bit_tick !== e_bit || os_clk !== e_clk) bad++;
    end
    tests_run++;
    if (first_os !== 2 || bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL en_resume: first os %0d with %0d bad cycles, expected 2 with 0", first_os, bad);
    end
  endtask

  task automatic test_reset_pending();
    int guard, bad, first_os;
    guard = 0;
    while (m_n % m_d != 0 && guard < 10) begin
      cycle();
      model_edge(1'b1);
      guard++;
    end
    div_load = 1; div_in = DW'(9); cycle(); div_load = 0;
    reset = 1; cycle(); reset = 0;
    tests_run++;
    if (div_cur !== DW'(DEF)) begin
      tests_failed++;
      $display("[TB] FAIL reset_pending_div: got %0d, expected %0d", div_cur, DEF);
    end
    model_restart(DEF);
    bad = 0; first_os = -1;
    for (int k = 1; k <= 700; k++) begin
      cycle();
      model_edge(1'b1);
      if (os_tick === 1'b1 && first_os < 0) first_os = k;
      if (os_tick !== e_os || os_clk !== e_clk || div_cur !== DW'(DEF)) bad++;
    end
    tests_run++;
    if (first_os !== 651 || bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pending_lost: first os %0d with %0d bad cycles, expected 651 with 0", first_os, bad);
    end
  endtask

  task automatic test_random();
    int d, bad;
    bit en_v, zl;
    for (int r = 0; r < 6; r++) begin
      reset = 1; en = 0; cycle(); reset = 0;
      d = (r == 0) ? 1 : int'($urandom_range(2, 12));
      div_load = 1; div_in = DW'(d); cycle();
      div_load = 0; cycle();
      model_restart(d);
      bad = 0;
      for (int k = 0; k < 400; k++) begin
        en_v = ($urandom_range(0, 3) != 0);
        zl   = ($urandom_range(0, 19) == 0);
        en = en_v; div_load = zl; div_in = '0;
        cycle();
        model_edge(en_v);
        if (os_tick !== e_os || mid_tick !== e_mid || bit_tick !== e_bit ||
            os_clk !== e_clk || div_err !== zl || div_cur !== DW'(d)) bad++;
      end
      div_load = 0;
      tests_run++;
      if (bad !== 0) begin
        tests_failed++;
        $display("[TB] FAIL random_d%0d: %0d bad cycles, expected 0", d, bad);
      end
    end
  endtask

  initial begin
    reset = 1; en = 0; sync = 0; div_load = 0; div_in = '0;
    test_reset();
    test_small_div();
    test_live_reload();
    test_zero_load();
    test_sync();
    test_en_gating();
    test_reset_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
